shared_vram_arbiter: RTL and testbench



---
 rtl/ikari_vram_pkg.sv | 16 +
 rtl/vram_win_decode.sv | 20 ++
 rtl/shared_vram_arbiter.sv | 139 +++++++++++++
 tb/tb_shared_vram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ikari_vram_pkg.sv
// rtl/ikari_vram_pkg.sv - shared types and window constants for the VRAM arbiter
package ikari_vram_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2,
    ST_RELEASE = 2'd3
  } vram_arb_state_t;

  // Shared VRAM window: addr[15:14] must match HI, addr[13:11] must differ from LO_EXCL
  localparam logic [1:0] VRAM_WIN_HI      = 2'b11;
  localparam logic [2:0] VRAM_WIN_LO_EXCL = 3'b000;

endpackage

// File: rtl/vram_win_decode.sv
// rtl/vram_win_decode.sv - shared VRAM window hit and request qualification for one Z80 bus
module vram_win_decode
  import ikari_vram_pkg::*;
(
  input  logic       mreq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [4:0] addr,
  output logic       req
);

  logic hit;

  // A request is a memory cycle with an active strobe that lands in 0xC800-0xFFFF
  always_comb begin
    hit = (addr[4:3] == VRAM_WIN_HI) && (addr[2:0] != VRAM_WIN_LO_EXCL);
    req = ~mreq_n & hit & (~rd_n | ~wr_n);
  end

endmodule

// File: rtl/shared_vram_arbiter.sv
// rtl/shared_vram_arbiter.sv - CPU A/B arbiter for the shared video RAM banks
module shared_vram_arbiter
  import ikari_vram_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_mreq_n,
  input  logic       a_rd_n,
  input  logic       a_wr_n,
  input  logic [4:0] a_addr,
  input  logic       b_mreq_n,
  input  logic       b_rd_n,
  input  logic       b_wr_n,
  input  logic [4:0] b_addr,
  output logic       ab_sel,
  output logic       a_wait_n,
  output logic       b_wait_n,
  output logic       vram_rd_n,
  output logic       vram_wr_n,
  output logic       busy
);

  vram_arb_state_t state;
  vram_arb_state_t next_state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant_b;
  logic             a_req;
  logic             b_req;
  logic             entering_grant;
  logic             staying_grant;
  logic             slot_done;

  vram_win_decode u_dec_a (
    .mreq_n (a_mreq_n),
    .rd_n   (a_rd_n),
    .wr_n   (a_wr_n),
    .addr   (a_addr),
    .req    (a_req)
  );

  vram_win_decode u_dec_b (
    .mreq_n (b_mreq_n),
    .rd_n   (b_rd_n),
    .wr_n   (b_wr_n),
    .addr   (b_addr),
    .req    (b_req)
  );

  // Next-state: grant from IDLE (round-robin on ties), hold while the owner requests
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (a_req && b_req) begin
          next_state = last_grant_b ? ST_GRANT_A : ST_GRANT_B;
        end else if (a_req) begin
          next_state = ST_GRANT_A;
        end else if (b_req) begin
          next_state = ST_GRANT_B;
        end
      end
      ST_GRANT_A: if (!a_req) next_state = ST_RELEASE;
      ST_GRANT_B: if (!b_req) next_state = ST_RELEASE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    entering_grant = (state == ST_IDLE) &&
                     ((next_state == ST_GRANT_A) || (next_state == ST_GRANT_B));
    staying_grant  = ((state == ST_GRANT_A) || (state == ST_GRANT_B)) &&
                     (next_state == state);
    slot_done      = (cnt == '0);
  end

  // Slot counter: loaded on grant entry, counts down to zero while the grant is held
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (entering_grant) begin
      cnt <= CNT_W'(HOLD_CYCLES);
    end else if (staying_grant && !slot_done) begin
      cnt <= cnt - CNT_W'(1);
    end else if (!staying_grant) begin
      cnt <= '0;
    end
  end

  // Bus select only moves when leaving IDLE, so it never changes under an active strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      ab_sel <= 1'b0;
    end else if (entering_grant) begin
      ab_sel <= (next_state == ST_GRANT_B);
    end
  end

  // Round-robin bit: only a tie consumes a turn; reset favours CPU A
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_b <= 1'b1;
    end else if ((state == ST_IDLE) && a_req && b_req) begin
      last_grant_b <= ~last_grant_b;
    end
  end

  // WAIT lines and muxed strobes; WAIT is forced released while reset is held
  always_comb begin
    a_wait_n  = reset | ~(a_req & ~((state == ST_GRANT_A) && slot_done));
    b_wait_n  = reset | ~(b_req & ~((state == ST_GRANT_B) && slot_done));
    vram_rd_n = 1'b1;
    vram_wr_n = 1'b1;
    case (state)
      ST_GRANT_A: begin
        vram_rd_n = a_rd_n;
        vram_wr_n = a_wr_n;
      end
      ST_GRANT_B: begin
        vram_rd_n = b_rd_n;
        vram_wr_n = b_wr_n;
      end
      default: ;
    endcase
    busy = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_shared_vram_arbiter.sv
// tb/tb_shared_vram_arbiter.sv - self-checking bench for shared_vram_arbiter
module tb_shared_vram_arbiter;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_mreq_n = 1'b1, a_rd_n = 1'b1, a_wr_n = 1'b1;
  logic [4:0] a_addr = 5'd0;
  logic       b_mreq_n = 1'b1, b_rd_n = 1'b1, b_wr_n = 1'b1;
  logic [4:0] b_addr = 5'd0;
  logic       ab_sel, a_wait_n, b_wait_n, vram_rd_n, vram_wr_n, busy;
  logic       d1_ab_sel, d1_a_wait_n, d1_b_wait_n, d1_vram_rd_n, d1_vram_wr_n, d1_busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  shared_vram_arbiter #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .a_mreq_n(a_mreq_n), .a_rd_n(a_rd_n), .a_wr_n(a_wr_n), .a_addr(a_addr),
    .b_mreq_n(b_mreq_n), .b_rd_n(b_rd_n), .b_wr_n(b_wr_n), .b_addr(b_addr),
    .ab_sel(ab_sel), .a_wait_n(a_wait_n), .b_wait_n(b_wait_n),
    .vram_rd_n(vram_rd_n), .vram_wr_n(vram_wr_n), .busy(busy)
  );

  shared_vram_arbiter #(.HOLD_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset),
    .a_mreq_n(a_mreq_n), .a_rd_n(a_rd_n), .a_wr_n(a_wr_n), .a_addr(a_addr),
    .b_mreq_n(b_mreq_n), .b_rd_n(b_rd_n), .b_wr_n(b_wr_n), .b_addr(b_addr),
    .ab_sel(d1_ab_sel), .a_wait_n(d1_a_wait_n), .b_wait_n(d1_b_wait_n),
    .vram_rd_n(d1_vram_rd_n), .vram_wr_n(d1_vram_wr_n), .busy(d1_busy)
  );

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how many edges it has held it, release tick pending
  int m_owner   = 0;   // 0 none, 1 A, 2 B
  int m_elapsed = 0;
  bit m_rel     = 1'b0;
  bit m_ab      = 1'b0;
  int m_last    = 2;   // last tie winner

  function automatic bit req_f(logic mreq_n, logic rd_n, logic wr_n, logic [4:0] addr);
    logic [15:0] full;
    full = {addr, 11'd0};
    return !mreq_n && (!rd_n || !wr_n) && (full >= 16'hC800);
  endfunction

  always @(posedge clk) begin
    bit ra, rb;
    int w;
    ra = req_f(a_mreq_n, a_rd_n, a_wr_n, a_addr);
    rb = req_f(b_mreq_n, b_rd_n, b_wr_n, b_addr);
    if (reset) begin
      m_owner = 0; m_elapsed = 0; m_rel = 1'b0; m_ab = 1'b0; m_last = 2;
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else if (m_owner != 0) begin
      if ((m_owner == 1 && !ra) || (m_owner == 2 && !rb)) begin
        m_owner = 0;
        m_rel = 1'b1;
      end else if (m_elapsed < H) begin
        m_elapsed++;
      end
    end else begin
      w = 0;
      if (ra && rb) begin
        w = (m_last == 2) ? 1 : 2;
        m_last = w;
      end else if (ra) begin
        w = 1;
      end else if (rb) begin
        w = 2;
      end
      if (w != 0) begin
        m_owner = w;
        m_elapsed = 0;
        m_ab = (w == 2);
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    bit ra, rb, ea, eb, erd, ewr;
    if (chk_en) begin
      ra  = req_f(a_mreq_n, a_rd_n, a_wr_n, a_addr);
      rb  = req_f(b_mreq_n, b_rd_n, b_wr_n, b_addr);
      ea  = reset || !(ra && !(m_owner == 1 && m_elapsed >= H));
      eb  = reset || !(rb && !(m_owner == 2 && m_elapsed >= H));
      erd = (m_owner == 1) ? a_rd_n : (m_owner == 2) ? b_rd_n : 1'b1;
      ewr = (m_owner == 1) ? a_wr_n : (m_owner == 2) ? b_wr_n : 1'b1;
      check("model_ab_sel", 16'(ab_sel), 16'(m_ab));
      check("model_busy", 16'(busy), 16'(m_owner != 0 || m_rel));
      check("model_a_wait_n", 16'(a_wait_n), 16'(ea));
      check("model_b_wait_n", 16'(b_wait_n), 16'(eb));
      check("model_vram_rd_n", 16'(vram_rd_n), 16'(erd));
      check("model_vram_wr_n", 16'(vram_wr_n), 16'(ewr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_mreq_n = 1'b1; a_rd_n = 1'b1; a_wr_n = 1'b1;
  endtask

  task automatic idle_b();
    b_mreq_n = 1'b1; b_rd_n = 1'b1; b_wr_n = 1'b1;
  endtask

  initial begin
    int lat, lat1, cnt;
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    tick();
    check("reset_ab_sel", 16'(ab_sel), 16'd0);
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_a_wait_n", 16'(a_wait_n), 16'd1);
    check("reset_b_wait_n", 16'(b_wait_n), 16'd1);
    check("reset_vram_rd_n", 16'(vram_rd_n), 16'd1);

    // CPU A reads 0xE800 uncontended; also measure the HOLD_CYCLES=1 instance
    a_addr = 5'd29; a_mreq_n = 1'b0; a_rd_n = 1'b0;
    lat = 0; lat1 = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 1) begin
        check("a_read_ab_sel", 16'(ab_sel), 16'd0);
        check("a_read_vram_rd_n", 16'(vram_rd_n), 16'd0);
        check("a_read_a_wait_low", 16'(a_wait_n), 16'd0);
      end
      check("a_read_b_wait_n", 16'(b_wait_n), 16'd1);
      if (lat == 0 && a_wait_n) lat = e;
      if (lat1 == 0 && d1_a_wait_n) lat1 = e;
      if (lat != 0 && lat1 != 0) break;
    end
    check("a_latency_edges", 16'(lat), 16'(H + 1));
    check("a_latency_hold1_edges", 16'(lat1), 16'd2);
    idle_a();
    repeat (3) tick();

    // Tie on 0xF800 writes: A wins first
    a_addr = 5'd31; a_mreq_n = 1'b0; a_wr_n = 1'b0;
    b_addr = 5'd31; b_mreq_n = 1'b0; b_wr_n = 1'b0;
    for (int e = 1; e <= H + 1; e++) begin
      tick();
      if (e == 1) check("tie1_ab_sel", 16'(ab_sel), 16'd0);
    end
    check("tie1_a_released", 16'(a_wait_n), 16'd1);
    check("tie1_b_stalled", 16'(b_wait_n), 16'd0);
    idle_a();
    cnt = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (b_wait_n) begin
        cnt = e;
        break;
      end
    end
    check("tie1_b_wait_edges", 16'(cnt), 16'(H + 3));
    check("tie1_b_ab_sel", 16'(ab_sel), 16'd1);
    idle_b();
    repeat (3) tick();

    // Second tie: B wins, A (0xD000 read) stalls behind it
    a_addr = 5'd26; a_mreq_n = 1'b0; a_rd_n = 1'b0;
    b_addr = 5'd31; b_mreq_n = 1'b0; b_wr_n = 1'b0;
    for (int e = 1; e <= H + 1; e++) tick();
    check("tie2_b_released", 16'(b_wait_n), 16'd1);
    check("tie2_a_stalled", 16'(a_wait_n), 16'd0);
    check("tie2_ab_sel", 16'(ab_sel), 16'd1);
    idle_a(); idle_b();
    repeat (3) tick();

    // CPU B outside the window: 0xC000 then 0x8000
    b_addr = 5'd24; b_mreq_n = 1'b0; b_rd_n = 1'b0;
    repeat (4) tick();
    check("win_c000_busy", 16'(busy), 16'd0);
    check("win_c000_b_wait_n", 16'(b_wait_n), 16'd1);
    b_addr = 5'd16;
    repeat (4) tick();
    check("win_8000_busy", 16'(busy), 16'd0);
    check("win_8000_ab_sel", 16'(ab_sel), 16'd1);
    idle_b();
    tick();

    // Reset while B's counter sits at 2
    b_addr = 5'd29; b_mreq_n = 1'b0; b_rd_n = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_a_wait_n", 16'(a_wait_n), 16'd1);
    check("rst_b_wait_n", 16'(b_wait_n), 16'd1);
    check("rst_vram_rd_n", 16'(vram_rd_n), 16'd1);
    check("rst_ab_sel", 16'(ab_sel), 16'd0);
    reset = 1'b0;
    idle_b();
    repeat (3) tick();

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = ($urandom_range(299) == 0);
      if ($urandom_range(3) == 0) begin
        a_mreq_n = ($urandom_range(3) == 0);
        case ($urandom_range(2))
          0: begin a_rd_n = 1'b0; a_wr_n = 1'b1; end
          1: begin a_rd_n = 1'b1; a_wr_n = 1'b0; end
          default: begin a_rd_n = 1'b1; a_wr_n = 1'b1; end
        endcase
        a_addr = $urandom_range(1) ? 5'(25 + $urandom_range(6)) : 5'($urandom_range(31));
      end
      if ($urandom_range(3) == 0) begin
        b_mreq_n = ($urandom_range(3) == 0);
        case ($urandom_range(2))
          0: begin b_rd_n = 1'b0; b_wr_n = 1'b1; end
          1: begin b_rd_n = 1'b1; b_wr_n = 1'b0; end
          default: begin b_rd_n = 1'b1; b_wr_n = 1'b1; end
        endcase
        b_addr = $urandom_range(1) ? 5'(25 + $urandom_range(6)) : 5'($urandom_range(31));
      end
    end
    reset = 1'b0;
    idle_a(); idle_b();
    repeat (4) tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
